// File: rtl/seg7_scan_driver.sv
`timescale 1ns/1ps
// Eight-digit common-anode scan driver: double-buffered 5-bit character frame,
// per-slot blanking gap, commits only at frame wrap. Optional blink via SEG7_BLINK_EN.
module seg7_scan_driver #(
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLANK_CYCLES = 2000,
  parameter int BLINK_HALF   = 25000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [39:0] chars,
  input  logic        load,
  input  logic [7:0]  blink_mask,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        updated
);

  localparam int CNT_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [39:0] BLANK_FRAME = {8{5'h10}};

  typedef enum logic {ST_BLANK, ST_ON} state_t;

  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [39:0] shadow_q, shadow_d;
  logic [39:0] active_q, active_d;
  logic        pending_q, pending_d;
  logic        updated_q, updated_d;
  logic [7:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        slot_end, commit;
  logic [2:0]  digit_d;
  logic [4:0]  code_d;

`ifdef SEG7_BLINK_EN
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_phase_q, blink_phase_d;
`else
  logic unused_blink;
  assign unused_blink = ^{blink_mask, 32'(BLINK_HALF)};
`endif

  function automatic logic [6:0] decode(input logic [4:0] c);
    case (c)
      5'h00: decode = 7'h40;
      5'h01: decode = 7'h79;
      5'h02: decode = 7'h24;
      5'h03: decode = 7'h30;
      5'h04: decode = 7'h19;
      5'h05: decode = 7'h12;
      5'h06: decode = 7'h02;
      5'h07: decode = 7'h78;
      5'h08: decode = 7'h00;
      5'h09: decode = 7'h10;
      5'h0A: decode = 7'h0C;
      5'h0B: decode = 7'h03;
      5'h0C: decode = 7'h46;
      5'h0D: decode = 7'h47;
      5'h0E: decode = 7'h11;
      5'h0F: decode = 7'h42;
      5'h11: decode = 7'h61;
      5'h12: decode = 7'h12;
      5'h13: decode = 7'h06;
      5'h14: decode = 7'h07;
      5'h15: decode = 7'h41;
      default: decode = 7'h7F;
    endcase
  endfunction

  always_comb begin
    cnt_d     = cnt_q + 1'b1;
    idx_d     = idx_q;
    state_d   = state_q;
    slot_end  = (cnt_q == SLOT_LAST);
    if (slot_end) begin
      cnt_d   = '0;
      idx_d   = idx_q + 3'd1;
      state_d = ST_BLANK;
    end else if (cnt_q == BLANK_LAST) begin
      state_d = ST_ON;
    end

    // A load on the commit edge still lands in the shadow; the commit uses the old shadow.
    commit    = slot_end && (idx_q == 3'd7) && pending_q;
    active_d  = commit ? shadow_q : active_q;
    shadow_d  = load ? chars : shadow_q;
    pending_d = load | (pending_q & ~commit);
    updated_d = commit;

`ifdef SEG7_BLINK_EN
    blink_cnt_d   = blink_cnt_q + 1'b1;
    blink_phase_d = blink_phase_q;
    if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d   = '0;
      blink_phase_d = ~blink_phase_q;
    end
`endif

    // Outputs are computed from next-state values so an and seg always move together.
    digit_d = ~idx_d;
    code_d  = 5'h10;
    for (int i = 0; i < 8; i++) begin
      if (digit_d == 3'(i)) code_d = active_d[5*i +: 5];
    end
    an_d  = 8'hFF;
    seg_d = 7'h7F;
    if (state_d == ST_ON) begin
      an_d  = ~(8'h01 << digit_d);
      seg_d = decode(code_d);
`ifdef SEG7_BLINK_EN
      if (blink_phase_d && blink_mask[digit_d]) seg_d = 7'h7F;
`endif
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_BLANK;
      cnt_q     <= '0;
      idx_q     <= '0;
      shadow_q  <= BLANK_FRAME;
      active_q  <= BLANK_FRAME;
      pending_q <= 1'b0;
      updated_q <= 1'b0;
      an_q      <= 8'hFF;
      seg_q     <= 7'h7F;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      updated_q <= updated_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
    end
  end

`ifdef SEG7_BLINK_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end
`endif

  assign an      = an_q;
  assign seg     = seg_q;
  assign dp      = 1'b1;
  assign updated = updated_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
`timescale 1ns/1ps
// Bench for seg7_scan_driver: frame-level reference model (cycle count, shadow/active
// digit arrays, glyphs described by lit segment letters) checked every cycle.
module tb_seg7_scan_driver;

  localparam int DC    = 8;
  localparam int BC    = 2;
  localparam int BH    = 64;
  localparam int FRAME = DC * 8;

  logic        clock;
  logic        reset;
  logic [39:0] chars;
  logic        load;
  logic [7:0]  blink_mask;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        updated;

  seg7_scan_driver #(.DIGIT_CYCLES(DC), .BLANK_CYCLES(BC), .BLINK_HALF(BH)) dut (
    .clock(clock), .reset(reset), .chars(chars), .load(load),
    .blink_mask(blink_mask), .an(an), .seg(seg), .dp(dp), .updated(updated)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h time=%0t", tag, got, exp, $time);
    end
  endtask

  // glyph table: which segments a..g are lit
  string glyph[32];
  initial begin
    for (int i = 0; i < 32; i++) glyph[i] = "";
    glyph[0] = "abcdef"; glyph[1] = "bc";     glyph[2] = "abdeg";  glyph[3] = "abcdg";
    glyph[4] = "bcfg";   glyph[5] = "acdfg";  glyph[6] = "acdefg"; glyph[7] = "abc";
    glyph[8] = "abcdefg"; glyph[9] = "abcdfg";
    glyph[10] = "abefg"; glyph[11] = "cdefg"; glyph[12] = "adef";  glyph[13] = "def";
    glyph[14] = "bcdfg"; glyph[15] = "acdef"; glyph[17] = "bcde";  glyph[18] = "acdfg";
    glyph[19] = "adefg"; glyph[20] = "defg";  glyph[21] = "bcdef";
  end

  function automatic logic [6:0] seg_of(input logic [4:0] code);
    logic [6:0] m;
    string s;
    m = 7'h7F;
    s = glyph[code];
    for (int i = 0; i < s.len(); i++) m[s[i] - "a"] = 1'b0;
    return m;
  endfunction

  // reference model
  int         m_t;
  logic [4:0] m_shadow[8];
  logic [4:0] m_active[8];
  logic       m_pending;
  logic       m_upd;
  logic [31:0] exp_q[$];

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_t = 0;
      for (int i = 0; i < 8; i++) begin
        m_shadow[i] = 5'h10;
        m_active[i] = 5'h10;
      end
      m_pending = 1'b0;
      m_upd = 1'b0;
      exp_q.delete();
    end else begin
      m_upd = 1'b0;
      if ((m_t % FRAME) == FRAME - 1 && m_pending) begin
        for (int i = 0; i < 8; i++) m_active[i] = m_shadow[i];
        m_pending = 1'b0;
        m_upd = 1'b1;
      end
      if (load) begin
        for (int i = 0; i < 8; i++) m_shadow[i] = chars[5*i +: 5];
        m_pending = 1'b1;
      end
      m_t++;
      if (m_upd) exp_q.push_back(32'(m_t));
    end
  end

  // per-cycle output check
  always @(negedge clock) begin
    int slot, dig;
    logic [7:0] e_an;
    logic [6:0] e_seg;
    slot  = m_t % DC;
    dig   = 7 - ((m_t / DC) % 8);
    e_an  = 8'hFF;
    e_seg = 7'h7F;
    if (slot >= BC) begin
      e_an  = ~(8'h01 << dig);
      e_seg = seg_of(m_active[dig]);
`ifdef SEG7_BLINK_EN
      if (((m_t / BH) % 2) == 1 && blink_mask[dig]) e_seg = 7'h7F;
`endif
    end
    check_eq("an", 40'(an), 40'(e_an));
    check_eq("seg", 40'(seg), 40'(e_seg));
    check_eq("dp", 40'(dp), 40'd1);
    check_eq("updated", 40'(updated), 40'(m_upd));
    if (updated === 1'b1) begin
      if (exp_q.size() > 0) check_eq("upd_time", 40'(m_t), 40'(exp_q.pop_front()));
      else check_eq("upd_spurious", 40'(updated), 40'd0);
    end
  end

  // driver tasks
  task automatic wait_phase(input int p);
    int n;
    n = 0;
    @(negedge clock);
    while ((m_t % FRAME) != p && n < 3 * FRAME) begin
      @(negedge clock);
      n++;
    end
    check_eq("wait_phase", 40'(m_t % FRAME), 40'(p));
  endtask

  task automatic pulse_load(input logic [39:0] c);
    #1;
    chars = c;
    load  = 1'b1;
    @(negedge clock);
    #1;
    load  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic reset_pulse();
    #3;
    reset = 1'b0;
    #1;
    check_eq("rst_an", 40'(an), 40'hFF);
    check_eq("rst_seg", 40'(seg), 40'h7F);
    check_eq("rst_upd", 40'(updated), 40'd0);
    repeat (2) @(negedge clock);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    logic [39:0] rc;
    reset = 1'b0;
    load = 1'b0;
    chars = '0;
    blink_mask = 8'h00;
    repeat (3) @(negedge clock);
    check_eq("init_an", 40'(an), 40'hFF);
    check_eq("init_seg", 40'(seg), 40'h7F);
    check_eq("init_upd", 40'(updated), 40'd0);
    #1;
    reset = 1'b1;

    // idle scan of a blank frame
    idle(FRAME);

    // load at scan index 3: '0' on an[7], blank elsewhere
    wait_phase(3 * DC + 4);
    pulse_load({5'h00, {7{5'h10}}});
    idle(2 * FRAME);

    // two loads before one wrap: last one wins
    wait_phase(10);
    pulse_load({8{5'h01}});
    wait_phase(40);
    pulse_load({8{5'h08}});
    idle(2 * FRAME);

    // load coincident with the wrap edge while a frame of '1's is pending
    wait_phase(20);
    pulse_load({8{5'h01}});
    wait_phase(FRAME - 1);
    pulse_load({8{5'h13}});
    idle(3 * FRAME);

    // reset during an ON phase
    wait_phase(2 * DC + 5);
    reset_pulse();
    idle(FRAME + 4);

    // blink on an[7] with all digits 'E'
    blink_mask = 8'h80;
    wait_phase(30);
    pulse_load({8{5'h13}});
    idle(4 * FRAME);

    // randomized loads, masks, occasional reset
    for (int k = 0; k < 30; k++) begin
      idle($urandom_range(0, 90));
      #1;
      blink_mask = 8'($urandom);
      rc = {8'($urandom), 32'($urandom)};
      if ($urandom_range(0, 9) == 0) begin
        reset_pulse();
      end else begin
        pulse_load(rc);
      end
    end
    idle(2 * FRAME + 4);

    check_eq("upd_missing", 40'(exp_q.size()), 40'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
